// File: rtl/mem_wb_buf_pkg.sv
// Shared pipeline definitions for the MEM/WB writeback buffer: register bus
// widths, write-enable polarity, the zero word and buffer occupancy helpers.
package mem_wb_buf_pkg;

  localparam int          RegBus      = 32;
  localparam int          RegAddrBus  = 5;
  localparam logic        WriteEnable = 1'b1;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;

  // Occupancy of the two-entry buffer (0, 1 or 2 entries).
  typedef logic [1:0] occ_t;

  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_FULL  = 2'd2;

  // Pointers into a two-deep store simply toggle, which wraps modulo 2.
  function automatic logic ptr_inc(input logic ptr);
    return ~ptr;
  endfunction

endpackage

// File: rtl/mem_wb_buf_if.sv
// MEM -> WB buffer bus: retiring-instruction handshake, register-file write
// port and the two ID-stage bypass lookup ports.
interface mem_wb_buf_if import mem_wb_buf_pkg::*; #(
  parameter int DATA_W = RegBus,
  parameter int ADDR_W = RegAddrBus
) ();

  logic              flush_i;
  logic              mem_valid_i;
  logic              mem_ready_o;
  logic              mem_wreg_i;
  logic [ADDR_W-1:0] mem_waddr_i;
  logic [DATA_W-1:0] mem_wdata_i;
  logic              wb_stall_i;
  logic              wb_we_o;
  logic [ADDR_W-1:0] wb_waddr_o;
  logic [DATA_W-1:0] wb_wdata_o;
  logic [ADDR_W-1:0] fwd_raddr1_i;
  logic [ADDR_W-1:0] fwd_raddr2_i;
  logic              fwd_hit1_o;
  logic              fwd_hit2_o;
  logic [DATA_W-1:0] fwd_data1_o;
  logic [DATA_W-1:0] fwd_data2_o;

  // Buffer side.
  modport slave (
    input  flush_i, mem_valid_i, mem_wreg_i, mem_waddr_i, mem_wdata_i,
    input  wb_stall_i, fwd_raddr1_i, fwd_raddr2_i,
    output mem_ready_o, wb_we_o, wb_waddr_o, wb_wdata_o,
    output fwd_hit1_o, fwd_hit2_o, fwd_data1_o, fwd_data2_o
  );

  // Pipeline / control side.
  modport master (
    output flush_i, mem_valid_i, mem_wreg_i, mem_waddr_i, mem_wdata_i,
    output wb_stall_i, fwd_raddr1_i, fwd_raddr2_i,
    input  mem_ready_o, wb_we_o, wb_waddr_o, wb_wdata_o,
    input  fwd_hit1_o, fwd_hit2_o, fwd_data1_o, fwd_data2_o
  );

endinterface

// File: rtl/mem_wb_buf_skid_buf.sv
// Two-entry FIFO holding pending register writes. Exposes every slot plus the
// read pointer and occupancy so the parent can do head writeback and bypass.
module wb_skid_buf import mem_wb_buf_pkg::*; #(
  parameter int DATA_W = RegBus,
  parameter int ADDR_W = RegAddrBus
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   in_wreg,
  input  logic [ADDR_W-1:0]      in_waddr,
  input  logic [DATA_W-1:0]      in_wdata,
  output occ_t                   occ,
  output logic                   rd_ptr,
  output logic [1:0]             ent_wreg,
  output logic [1:0][ADDR_W-1:0] ent_waddr,
  output logic [1:0][DATA_W-1:0] ent_wdata
);

  logic                   wr_ptr_r;
  logic                   rd_ptr_r;
  occ_t                   occ_r;
  logic [1:0]             wreg_r;
  logic [1:0][ADDR_W-1:0] waddr_r;
  logic [1:0][DATA_W-1:0] wdata_r;

  // Pointer and occupancy state; flush empties the buffer in one edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      occ_r    <= OCC_EMPTY;
    end else if (flush) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      occ_r    <= OCC_EMPTY;
    end else begin
      wr_ptr_r <= push ? ptr_inc(wr_ptr_r) : wr_ptr_r;
      rd_ptr_r <= pop  ? ptr_inc(rd_ptr_r) : rd_ptr_r;
      case ({push, pop})
        2'b10:   occ_r <= occ_r + 2'd1;
        2'b01:   occ_r <= occ_r - 2'd1;
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Entry payload; left unreset because occupancy gates every use of it.
  always_ff @(posedge clk) begin
    if (push) begin
      wreg_r[wr_ptr_r]  <= in_wreg;
      waddr_r[wr_ptr_r] <= in_waddr;
      wdata_r[wr_ptr_r] <= in_wdata;
    end
  end

  assign occ       = occ_r;
  assign rd_ptr    = rd_ptr_r;
  assign ent_wreg  = wreg_r;
  assign ent_waddr = waddr_r;
  assign ent_wdata = wdata_r;

endmodule

// File: rtl/mem_wb_buf.sv
// MEM/WB writeback buffer: decouples MEM-stage retirement from a register
// file write port that can stall, and bypasses pending writes to ID.
module mem_wb_buf import mem_wb_buf_pkg::*; #(
  parameter int DATA_W = RegBus,
  parameter int ADDR_W = RegAddrBus
) (
  input logic          clk,
  input logic          rst,
  mem_wb_buf_if.slave  bus
);

  occ_t                   occ_s;
  logic                   rd_ptr_s;
  logic [1:0]             ent_wreg_s;
  logic [1:0][ADDR_W-1:0] ent_waddr_s;
  logic [1:0][DATA_W-1:0] ent_wdata_s;
  logic                   ready_s;
  logic                   push_s;
  logic                   pop_s;
  logic                   we_s;
  logic [ADDR_W-1:0]      waddr_s;
  logic [DATA_W-1:0]      wdata_s;
  logic                   hit1_s;
  logic                   hit2_s;
  logic [DATA_W-1:0]      data1_s;
  logic [DATA_W-1:0]      data2_s;

  // A slot forwards only if it really writes a non-zero register.
  function automatic logic ent_match(input logic wreg, input logic [ADDR_W-1:0] waddr,
                                     input logic [ADDR_W-1:0] raddr);
    return (wreg == WriteEnable) && (waddr != {ADDR_W{1'b0}}) && (waddr == raddr);
  endfunction

  // Older slot is checked first so the youngest matching write wins.
  function automatic logic [DATA_W:0] fwd_lookup(
    input logic [ADDR_W-1:0]      raddr,
    input occ_t                   occ,
    input logic                   rd_ptr,
    input logic [1:0]             wreg,
    input logic [1:0][ADDR_W-1:0] waddr,
    input logic [1:0][DATA_W-1:0] wdata
  );
    logic [DATA_W:0] res;
    logic            young;
    res   = {(DATA_W+1){1'b0}};
    young = rd_ptr ^ (occ == OCC_FULL);
    if ((occ == OCC_FULL) && ent_match(wreg[rd_ptr], waddr[rd_ptr], raddr)) begin
      res = {1'b1, wdata[rd_ptr]};
    end else begin
      res = res;
    end
    if ((occ != OCC_EMPTY) && ent_match(wreg[young], waddr[young], raddr)) begin
      res = {1'b1, wdata[young]};
    end else begin
      res = res;
    end
    return res;
  endfunction

  wb_skid_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.flush_i),
    .push      (push_s),
    .pop       (pop_s),
    .in_wreg   (bus.mem_wreg_i),
    .in_waddr  (bus.mem_waddr_i),
    .in_wdata  (bus.mem_wdata_i),
    .occ       (occ_s),
    .rd_ptr    (rd_ptr_s),
    .ent_wreg  (ent_wreg_s),
    .ent_waddr (ent_waddr_s),
    .ent_wdata (ent_wdata_s)
  );

  // Handshake: ready depends only on occupancy and reset, never on the stall.
  always_comb begin
    ready_s = rst && (occ_s != OCC_FULL);
    push_s  = bus.mem_valid_i && ready_s && !bus.flush_i;
    pop_s   = (occ_s != OCC_EMPTY) && !bus.wb_stall_i && !bus.flush_i;
  end

  // Register-file write port driven from the head entry.
  always_comb begin
    we_s    = 1'b0;
    waddr_s = {ADDR_W{1'b0}};
    wdata_s = {DATA_W{1'b0}};
    if (occ_s != OCC_EMPTY) begin
      waddr_s = ent_waddr_s[rd_ptr_s];
      wdata_s = ent_wdata_s[rd_ptr_s];
      we_s    = pop_s && (ent_wreg_s[rd_ptr_s] == WriteEnable)
                && (ent_waddr_s[rd_ptr_s] != {ADDR_W{1'b0}});
    end else begin
      we_s = 1'b0;
    end
  end

  // Bypass lookup for ID read port 1.
  always_comb begin
    {hit1_s, data1_s} = fwd_lookup(bus.fwd_raddr1_i, occ_s, rd_ptr_s,
                                   ent_wreg_s, ent_waddr_s, ent_wdata_s);
  end

  // Bypass lookup for ID read port 2.
  always_comb begin
    {hit2_s, data2_s} = fwd_lookup(bus.fwd_raddr2_i, occ_s, rd_ptr_s,
                                   ent_wreg_s, ent_waddr_s, ent_wdata_s);
  end

  assign bus.mem_ready_o = ready_s;
  assign bus.wb_we_o     = we_s;
  assign bus.wb_waddr_o  = waddr_s;
  assign bus.wb_wdata_o  = wdata_s;
  assign bus.fwd_hit1_o  = hit1_s;
  assign bus.fwd_hit2_o  = hit2_s;
  assign bus.fwd_data1_o = data1_s;
  assign bus.fwd_data2_o = data2_s;

endmodule

// File: tb/tb_mem_wb_buf.sv
// Self-checking bench for mem_wb_buf: directed scenarios plus a randomized
// run checked against a queue-based model of the pending-write buffer.
module tb_mem_wb_buf;
  import mem_wb_buf_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_wb_buf_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  mem_wb_buf #(.DATA_W(DW), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic          wreg;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
  } ent_t;

  ent_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // ---------------- reference model ----------------
  function automatic logic m_ready();
    return rst && (q.size() < 2);
  endfunction

  function automatic logic m_we();
    if (q.size() == 0) return 1'b0;
    return !bus.wb_stall_i && !bus.flush_i && q[0].wreg && (q[0].waddr != 0);
  endfunction

  function automatic logic [AW-1:0] m_waddr();
    if (q.size() == 0) return '0;
    return q[0].waddr;
  endfunction

  function automatic logic [DW-1:0] m_wdata();
    if (q.size() == 0) return '0;
    return q[0].wdata;
  endfunction

  // {hit, data}: youngest pending write to a non-zero register wins.
  function automatic logic [DW:0] m_fwd(input logic [AW-1:0] a);
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].wreg && q[i].waddr == a && a != 0) return {1'b1, q[i].wdata};
    end
    return '0;
  endfunction

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic st, input logic fl,
                       input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    bus.mem_valid_i  = v;
    bus.mem_wreg_i   = wr;
    bus.mem_waddr_i  = a;
    bus.mem_wdata_i  = d;
    bus.wb_stall_i   = st;
    bus.flush_i      = fl;
    bus.fwd_raddr1_i = r1;
    bus.fwd_raddr2_i = r2;
    #2;
  endtask

  // Advance one clock edge and apply the buffer rules to the model.
  task automatic tick();
    logic acc, ret;
    ent_t e;
    acc = bus.mem_valid_i && m_ready() && !bus.flush_i;
    ret = (q.size() > 0) && !bus.wb_stall_i && !bus.flush_i;
    e   = '{wreg: bus.mem_wreg_i, waddr: bus.mem_waddr_i, wdata: bus.mem_wdata_i};
    @(posedge clk);
    if (!rst || bus.flush_i) q.delete();
    else begin
      if (ret) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive(1'b1, 1'b1, 5'd3, 32'h1234_5678, 1'b0, 1'b0, 5'd3, 5'd4);
    n_checks++; if (bus.mem_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %0b want 0", bus.mem_ready_o); end
    n_checks++; if (bus.wb_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_we got %0b want 0", bus.wb_we_o); end
    n_checks++; if (bus.wb_waddr_o !== 5'd0 || bus.wb_wdata_o !== 32'd0) begin n_fail++; $display("FAIL reset_wport got %0h/%0h want 0/0", bus.wb_waddr_o, bus.wb_wdata_o); end
    n_checks++; if ({bus.fwd_hit1_o, bus.fwd_hit2_o, bus.fwd_data1_o, bus.fwd_data2_o} !== 66'd0) begin n_fail++; $display("FAIL reset_fwd got %0b%0b %0h %0h want all 0", bus.fwd_hit1_o, bus.fwd_hit2_o, bus.fwd_data1_o, bus.fwd_data2_o); end
    tick();
    rst = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    n_checks++; if (bus.mem_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got %0b want 1", bus.mem_ready_o); end
    tick();
  endtask

  task automatic test_single();
    drive(1'b1, 1'b1, 5'd3, 32'h1111_1111, 1'b0, 1'b0, 5'd3, 5'd0);
    n_checks++; if (bus.mem_ready_o !== 1'b1 || bus.wb_we_o !== 1'b0) begin n_fail++; $display("FAIL single_accept ready/we got %0b/%0b want 1/0", bus.mem_ready_o, bus.wb_we_o); end
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd3, 5'd0);
    n_checks++; if (bus.wb_we_o !== 1'b1 || bus.wb_waddr_o !== 5'd3 || bus.wb_wdata_o !== 32'h1111_1111) begin n_fail++; $display("FAIL single_write got we=%0b a=%0d d=%0h want 1/3/11111111", bus.wb_we_o, bus.wb_waddr_o, bus.wb_wdata_o); end
    n_checks++; if (bus.fwd_hit1_o !== 1'b1 || bus.fwd_data1_o !== 32'h1111_1111) begin n_fail++; $display("FAIL single_head_bypass got %0b/%0h want 1/11111111", bus.fwd_hit1_o, bus.fwd_data1_o); end
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd3, 5'd0);
    n_checks++; if (bus.wb_we_o !== 1'b0 || bus.fwd_hit1_o !== 1'b0) begin n_fail++; $display("FAIL single_after we/hit got %0b/%0b want 0/0", bus.wb_we_o, bus.fwd_hit1_o); end
    tick();
  endtask

  task automatic test_stall();
    drive(1'b1, 1'b1, 5'd4, 32'hA, 1'b1, 1'b0, 5'd4, 5'd5);
    n_checks++; if (bus.mem_ready_o !== 1'b1 || bus.wb_we_o !== 1'b0) begin n_fail++; $display("FAIL stall_push1 ready/we got %0b/%0b want 1/0", bus.mem_ready_o, bus.wb_we_o); end
    tick();
    drive(1'b1, 1'b1, 5'd5, 32'hB, 1'b1, 1'b0, 5'd4, 5'd5);
    n_checks++; if (bus.mem_ready_o !== 1'b1 || bus.fwd_hit1_o !== 1'b1 || bus.fwd_data1_o !== 32'hA) begin n_fail++; $display("FAIL stall_push2 ready/hit/data got %0b/%0b/%0h want 1/1/a", bus.mem_ready_o, bus.fwd_hit1_o, bus.fwd_data1_o); end
    tick();
    drive(1'b1, 1'b1, 5'd6, 32'hC, 1'b1, 1'b0, 5'd4, 5'd5);
    n_checks++; if (bus.mem_ready_o !== 1'b0 || bus.wb_we_o !== 1'b0) begin n_fail++; $display("FAIL stall_full ready/we got %0b/%0b want 0/0", bus.mem_ready_o, bus.wb_we_o); end
    tick();
    drive(1'b1, 1'b1, 5'd6, 32'hC, 1'b0, 1'b0, 5'd0, 5'd0);
    n_checks++; if (bus.mem_ready_o !== 1'b0 || bus.wb_we_o !== 1'b1 || bus.wb_waddr_o !== 5'd4 || bus.wb_wdata_o !== 32'hA) begin n_fail++; $display("FAIL stall_wr4 got rdy=%0b we=%0b a=%0d d=%0h want 0/1/4/a", bus.mem_ready_o, bus.wb_we_o, bus.wb_waddr_o, bus.wb_wdata_o); end
    tick();
    drive(1'b1, 1'b1, 5'd6, 32'hC, 1'b0, 1'b0, 5'd0, 5'd0);
    n_checks++; if (bus.mem_ready_o !== 1'b1 || bus.wb_we_o !== 1'b1 || bus.wb_waddr_o !== 5'd5 || bus.wb_wdata_o !== 32'hB) begin n_fail++; $display("FAIL stall_wr5 got rdy=%0b we=%0b a=%0d d=%0h want 1/1/5/b", bus.mem_ready_o, bus.wb_we_o, bus.wb_waddr_o, bus.wb_wdata_o); end
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    n_checks++; if (bus.wb_we_o !== 1'b1 || bus.wb_waddr_o !== 5'd6 || bus.wb_wdata_o !== 32'hC) begin n_fail++; $display("FAIL stall_wr6 got we=%0b a=%0d d=%0h want 1/6/c", bus.wb_we_o, bus.wb_waddr_o, bus.wb_wdata_o); end
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    n_checks++; if (bus.wb_we_o !== 1'b0 || bus.mem_ready_o !== 1'b1) begin n_fail++; $display("FAIL stall_drained we/ready got %0b/%0b want 0/1", bus.wb_we_o, bus.mem_ready_o); end
    tick();
  endtask

  task automatic test_zero_dest();
    drive(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd0, 5'd7);
    tick();
    drive(1'b1, 1'b0, 5'd7, 32'h77, 1'b0, 1'b0, 5'd0, 5'd7);
    n_checks++; if (bus.wb_we_o !== 1'b0 || bus.wb_waddr_o !== 5'd0 || bus.wb_wdata_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL zero_r0 got we=%0b a=%0d d=%0h want 0/0/ffffffff", bus.wb_we_o, bus.wb_waddr_o, bus.wb_wdata_o); end
    n_checks++; if (bus.fwd_hit1_o !== 1'b0 || bus.fwd_data1_o !== 32'd0) begin n_fail++; $display("FAIL zero_r0_fwd got %0b/%0h want 0/0", bus.fwd_hit1_o, bus.fwd_data1_o); end
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd7);
    n_checks++; if (bus.wb_we_o !== 1'b0 || bus.wb_waddr_o !== 5'd7 || bus.fwd_hit2_o !== 1'b0) begin n_fail++; $display("FAIL zero_r7 got we=%0b a=%0d hit2=%0b want 0/7/0", bus.wb_we_o, bus.wb_waddr_o, bus.fwd_hit2_o); end
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    n_checks++; if (bus.wb_waddr_o !== 5'd0 || bus.mem_ready_o !== 1'b1) begin n_fail++; $display("FAIL zero_drained a/ready got %0d/%0b want 0/1", bus.wb_waddr_o, bus.mem_ready_o); end
    tick();
  endtask

  task automatic test_bypass_and_flush();
    drive(1'b1, 1'b1, 5'd8, 32'h1, 1'b1, 1'b0, 5'd8, 5'd9);
    tick();
    drive(1'b1, 1'b1, 5'd8, 32'h2, 1'b1, 1'b0, 5'd8, 5'd9);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd8, 5'd9);
    n_checks++; if (bus.fwd_hit1_o !== 1'b1 || bus.fwd_data1_o !== 32'h2) begin n_fail++; $display("FAIL bypass_young got %0b/%0h want 1/2", bus.fwd_hit1_o, bus.fwd_data1_o); end
    n_checks++; if (bus.fwd_hit2_o !== 1'b0 || bus.fwd_data2_o !== 32'd0) begin n_fail++; $display("FAIL bypass_miss got %0b/%0h want 0/0", bus.fwd_hit2_o, bus.fwd_data2_o); end
    tick();
    drive(1'b1, 1'b1, 5'd12, 32'h5, 1'b1, 1'b1, 5'd8, 5'd9);
    n_checks++; if (bus.wb_we_o !== 1'b0 || bus.mem_ready_o !== 1'b0) begin n_fail++; $display("FAIL flush_cycle we/ready got %0b/%0b want 0/0", bus.wb_we_o, bus.mem_ready_o); end
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd8, 5'd12);
    n_checks++; if (bus.mem_ready_o !== 1'b1 || bus.wb_we_o !== 1'b0 || bus.wb_waddr_o !== 5'd0) begin n_fail++; $display("FAIL flush_empty rdy/we/a got %0b/%0b/%0d want 1/0/0", bus.mem_ready_o, bus.wb_we_o, bus.wb_waddr_o); end
    n_checks++; if (bus.fwd_hit1_o !== 1'b0 || bus.fwd_hit2_o !== 1'b0) begin n_fail++; $display("FAIL flush_fwd got %0b/%0b want 0/0", bus.fwd_hit1_o, bus.fwd_hit2_o); end
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, 5'd10, 32'hAA, 1'b1, 1'b0, 5'd10, 5'd11);
    tick();
    drive(1'b1, 1'b1, 5'd11, 32'hBB, 1'b1, 1'b0, 5'd10, 5'd11);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd10, 5'd11);
    rst = 1'b0;
    q.delete();
    #1;
    n_checks++; if ({bus.mem_ready_o, bus.wb_we_o, bus.wb_waddr_o, bus.wb_wdata_o} !== 39'd0) begin n_fail++; $display("FAIL rst_mid_wport got rdy=%0b we=%0b a=%0d d=%0h want all 0", bus.mem_ready_o, bus.wb_we_o, bus.wb_waddr_o, bus.wb_wdata_o); end
    n_checks++; if ({bus.fwd_hit1_o, bus.fwd_hit2_o, bus.fwd_data1_o, bus.fwd_data2_o} !== 66'd0) begin n_fail++; $display("FAIL rst_mid_fwd got %0b%0b %0h %0h want all 0", bus.fwd_hit1_o, bus.fwd_hit2_o, bus.fwd_data1_o, bus.fwd_data2_o); end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd10, 5'd11);
      n_checks++; if (bus.wb_we_o !== 1'b0 || bus.mem_ready_o !== 1'b1 || bus.fwd_hit1_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_after%0d we/rdy/hit got %0b/%0b/%0b want 0/1/0", i, bus.wb_we_o, bus.mem_ready_o, bus.fwd_hit1_o); end
      tick();
    end
  endtask

  task automatic test_random();
    logic [DW:0] f1, f2;
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)),
            $urandom, $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      f1 = m_fwd(bus.fwd_raddr1_i);
      f2 = m_fwd(bus.fwd_raddr2_i);
      n_checks++; if (bus.mem_ready_o !== m_ready()) begin n_fail++; $display("FAIL rand_ready c=%0d got %0b want %0b", c, bus.mem_ready_o, m_ready()); end
      n_checks++; if (bus.wb_we_o !== m_we()) begin n_fail++; $display("FAIL rand_we c=%0d got %0b want %0b", c, bus.wb_we_o, m_we()); end
      n_checks++; if (bus.wb_waddr_o !== m_waddr() || bus.wb_wdata_o !== m_wdata()) begin n_fail++; $display("FAIL rand_wport c=%0d got %0d/%0h want %0d/%0h", c, bus.wb_waddr_o, bus.wb_wdata_o, m_waddr(), m_wdata()); end
      n_checks++; if ({bus.fwd_hit1_o, bus.fwd_data1_o} !== f1) begin n_fail++; $display("FAIL rand_fwd1 c=%0d got %0b/%0h want %0b/%0h", c, bus.fwd_hit1_o, bus.fwd_data1_o, f1[DW], f1[DW-1:0]); end
      n_checks++; if ({bus.fwd_hit2_o, bus.fwd_data2_o} !== f2) begin n_fail++; $display("FAIL rand_fwd2 c=%0d got %0b/%0h want %0b/%0h", c, bus.fwd_hit2_o, bus.fwd_data2_o, f2[DW], f2[DW-1:0]); end
      tick();
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_stall();
    test_zero_dest();
    test_bypass_and_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_buf.md
MEM_WB_BUF -- requirements
Module: mem_wb_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width (`RegBus`).
REQ-002 SHALL have parameter ADDR_W, default 5, register address width (`RegAddrBus`).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low: asserted when 0.
REQ-005 SHALL have port flush_i  input  1  synchronous pipeline flush from control.
REQ-006 SHALL have port mem_valid_i  input  1  MEM stage presents a retiring instruction.
REQ-007 SHALL have port mem_ready_o  output  1  buffer can accept this cycle.
REQ-008 SHALL have port mem_wreg_i  input  1  instruction writes a register.
REQ-009 SHALL have port mem_waddr_i  input  ADDR_W  destination register.
REQ-010 SHALL have port mem_wdata_i  input  DATA_W  result data.
REQ-011 SHALL have port wb_stall_i  input  1  register-file write port unavailable this cycle.
REQ-012 SHALL have port wb_we_o  output  1  register-file write enable.
REQ-013 SHALL have port wb_waddr_o  output  ADDR_W  register-file write address.
REQ-014 SHALL have port wb_wdata_o  output  DATA_W  register-file write data.
REQ-015 SHALL have ports fwd_raddr1_i / fwd_raddr2_i  input  ADDR_W  ID read addresses for bypass lookup.
REQ-016 SHALL have ports fwd_hit1_o / fwd_hit2_o  output  1  buffered pending write matches the address.
REQ-017 SHALL have ports fwd_data1_o / fwd_data2_o  output  DATA_W  bypass data, zero when no hit.

Function
REQ-018 SHALL hold up to 2 entries {wreg, waddr, wdata} in FIFO order (occupancy 0..2).
REQ-019 SHALL drive mem_ready_o = 1 when occupancy < 2 and rst deasserted, else 0; no combinational path from wb_stall_i.
REQ-020 SHALL accept an entry on a rising edge when mem_valid_i && mem_ready_o && !flush_i.
REQ-021 SHALL retire the head entry on a rising edge when occupancy > 0 && !wb_stall_i && !flush_i.
REQ-022 SHALL drive wb_we_o = head.wreg && head.waddr != 0 && occupancy > 0 && !wb_stall_i && !flush_i.
REQ-023 SHALL drive wb_waddr_o/wb_wdata_o from the head entry when occupancy > 0, else all zero.
REQ-024 SHALL make an entry accepted at edge N visible on wb_we_o in cycle N+1 (one-cycle latency, empty buffer, no stall).
REQ-025 SHALL retire entries with wreg=0 or waddr=0 normally, consuming one slot, with wb_we_o=0.
REQ-026 SHALL keep occupancy unchanged on simultaneous accept and retire (only reachable at occupancy 1 or 0→ n/a).
REQ-027 SHALL not accept when full, even if a retire occurs that same cycle.
REQ-028 SHALL, on flush_i=1, empty the buffer at the next edge, ignore mem_valid_i, and force wb_we_o=0 that cycle.
REQ-029 SHALL wrap read/write pointers modulo 2 without data loss across arbitrarily many transactions.
REQ-030 SHALL compute fwd_hitK_o = 1 when any valid entry has wreg=1, waddr==fwd_raddrK_i, waddr!=0; fwd_dataK_o from the youngest such entry.
REQ-031 SHALL include the head entry in bypass lookup even in the cycle it retires.

Reset
REQ-032 SHALL, while rst=0, clear occupancy and pointers and drive mem_ready_o, wb_we_o, wb_waddr_o, wb_wdata_o, fwd_hit*_o, fwd_data*_o to 0.
REQ-033 SHALL discard buffered entries on reset assertion mid-operation; no write issued after release until new accept.
REQ-034 SHALL not require entry data storage to be reset (valid bits gate all use).

Structure
REQ-035 SHALL take RegBus, RegAddrBus, WriteEnable, ZeroWord from the shared Defines include; no new local copies.
REQ-036 SHALL implement storage/pointers in one sub-module wb_skid_buf (2-entry FIFO with occupancy out); bypass match in top level.

Verification
REQ-037 Empty, no stall: accept {1,r3,0x11111111} -> next cycle wb_we_o=1, waddr=3, wdata=0x11111111; then wb_we_o=0.
REQ-038 wb_stall_i=1 for 3 cycles, push r4=0xA, r5=0xB, r6=0xC -> ready drops after 2 accepts; r6 held off; release -> writes r4, r5, r6 in order.
REQ-039 Push r0=0xFFFFFFFF wreg=1, then r7 wreg=0 -> both retire with wb_we_o=0; fwd_hit never set for addr 0.
REQ-040 Stalled buffer holding r8=0x1, r8=0x2, fwd_raddr1_i=8 -> fwd_hit1_o=1, fwd_data1_o=0x2; fwd_raddr2_i=9 -> hit 0, data 0.
REQ-041 Full buffer, flush_i=1 with mem_valid_i=1 -> next cycle occupancy 0, ready=1, no write issued; rst=0 mid-stall -> all outputs 0 asynchronously.
